// File: rtl/led_pkg.sv
// Shared constants and types for the LED frame buffer.
package led_pkg;

    localparam int unsigned ROWS_DEF   = 8;
    localparam int unsigned COLS_DEF   = 8;
    localparam int unsigned PIX_W_DEF  = 4;

    // Pixel bit positions at the default pixel width.
    localparam int unsigned PIX_STORED = 3;
    localparam int unsigned PIX_G      = 2;
    localparam int unsigned PIX_R      = 1;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/led_frame_buf_if.sv
// Pixel write/read, clear and swap signals between controller and frame buffer.
interface led_frame_buf_if #(
    parameter int unsigned ROW_AW = 3,
    parameter int unsigned COL_AW = 3,
    parameter int unsigned PIX_W  = 4
);
    logic              we;
    logic [ROW_AW-1:0] wr_row;
    logic [COL_AW-1:0] wr_col;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_drop;
    logic              rd_en;
    logic [ROW_AW-1:0] rd_row;
    logic [COL_AW-1:0] rd_col;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic              clr_req;
    logic              clr_busy;
    logic              swap_req;
    logic              frame_sync;
    logic              swap_pend;
    logic              front_sel;

    modport master (
        output we, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col,
               clr_req, swap_req, frame_sync,
        input  wr_drop, rd_data, rd_valid, clr_busy, swap_pend, front_sel
    );

    modport slave (
        input  we, wr_row, wr_col, wr_data, rd_en, rd_row, rd_col,
               clr_req, swap_req, frame_sync,
        output wr_drop, rd_data, rd_valid, clr_busy, swap_pend, front_sel
    );
endinterface

// File: rtl/led_clr_seq.sv
// Clear sequencer: walks every pixel once, column index innermost.
module led_clr_seq
    import led_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROW_AW = 3,
    parameter int unsigned COL_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ROW_AW-1:0] row,
    output logic [COL_AW-1:0] col,
    output logic              wr
);

    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);
    localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(COLS - 1);

    clr_state_t        state, state_nxt;
    logic [ROW_AW-1:0] row_q, row_nxt;
    logic [COL_AW-1:0] col_q, col_nxt;

    // State and address counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            row_q <= '0;
            col_q <= '0;
        end else begin
            state <= state_nxt;
            row_q <= row_nxt;
            col_q <= col_nxt;
        end
    end

    // Next state: stop after the last row's last column, no power-of-two wrap.
    always_comb begin
        state_nxt = state;
        row_nxt   = row_q;
        col_nxt   = col_q;
        case (state)
            CLR_IDLE: begin
                if (start) begin
                    state_nxt = CLR_RUN;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            CLR_RUN: begin
                if (col_q == COL_LAST) begin
                    col_nxt = '0;
                    if (row_q == ROW_LAST) begin
                        state_nxt = CLR_IDLE;
                        row_nxt   = '0;
                    end else begin
                        row_nxt = row_q + ROW_AW'(1);
                    end
                end else begin
                    col_nxt = col_q + COL_AW'(1);
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    assign busy = (state == CLR_RUN);
    assign wr   = (state == CLR_RUN);
    assign row  = row_q;
    assign col  = col_q;

endmodule

// File: rtl/led_frame_buf.sv
// Double-buffered LED frame memory with frame-synchronised swap and clear engine.
module led_frame_buf
    import led_pkg::*;
#(
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned ROW_AW = 3,
    parameter int unsigned COL_AW = 3
) (
    input logic             clk,
    input logic             rst_n,
    led_frame_buf_if.slave  bus
);

    localparam int unsigned RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CI_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_AW:0] ROW_LIM = (ROW_AW + 1)'(ROWS);
    localparam logic [COL_AW:0] COL_LIM = (COL_AW + 1)'(COLS);

    logic [PIX_W-1:0]  mem [2][ROWS][COLS];
    logic              front_sel;
    logic              swap_pend;
    logic              clr_buf;
    logic              clr_busy;
    logic              clr_wr;
    logic [ROW_AW-1:0] clr_row;
    logic [COL_AW-1:0] clr_col;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic              wr_drop;

    logic wr_in_rng;
    logic rd_in_rng;
    logic clr_go;
    logic swap_go;
    logic wr_ok;

    assign wr_in_rng = ({1'b0, bus.wr_row} < ROW_LIM) && ({1'b0, bus.wr_col} < COL_LIM);
    assign rd_in_rng = ({1'b0, bus.rd_row} < ROW_LIM) && ({1'b0, bus.rd_col} < COL_LIM);
    assign clr_go    = bus.clr_req && !clr_busy;
    assign swap_go   = swap_pend && bus.frame_sync && !clr_busy;
    // A clear starting this cycle already owns the back buffer.
    assign wr_ok     = bus.we && wr_in_rng && !clr_busy && !clr_go;

    led_clr_seq #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ROW_AW (ROW_AW),
        .COL_AW (COL_AW)
    ) u_clr_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (clr_go),
        .busy  (clr_busy),
        .row   (clr_row),
        .col   (clr_col),
        .wr    (clr_wr)
    );

    // Swap request tracking; clear target is the back buffer after any same-cycle swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            swap_pend <= 1'b0;
            clr_buf   <= 1'b1;
        end else begin
            if (swap_go) begin
                front_sel <= ~front_sel;
                swap_pend <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pend <= 1'b1;
            end
            if (clr_go) begin
                clr_buf <= swap_go ? front_sel : ~front_sel;
            end
        end
    end

    // Pixel storage: clear engine or controller writes into the back buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    for (int c = 0; c < int'(COLS); c++) begin
                        mem[b][r][c] <= '0;
                    end
                end
            end
        end else if (clr_wr) begin
            mem[clr_buf][RI_W'(clr_row)][CI_W'(clr_col)] <= '0;
        end else if (wr_ok) begin
            mem[~front_sel][RI_W'(bus.wr_row)][CI_W'(bus.wr_col)] <= bus.wr_data;
        end
    end

    // Registered front-buffer read and write-drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            wr_drop  <= bus.we && !wr_ok;
            if (bus.rd_en) begin
                rd_data <= rd_in_rng ? mem[front_sel][RI_W'(bus.rd_row)][CI_W'(bus.rd_col)] : '0;
            end
        end
    end

    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.wr_drop   = wr_drop;
    assign bus.clr_busy  = clr_busy;
    assign bus.swap_pend = swap_pend;
    assign bus.front_sel = front_sel;

endmodule

// File: tb/tb_led_frame_buf.sv
// Randomised and directed bench for led_frame_buf against a behavioural model.
module tb_led_frame_buf;
    import led_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NPIX = ROWS * COLS;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    led_frame_buf_if #(.ROW_AW(4), .COL_AW(4), .PIX_W(4)) bus ();

    led_frame_buf #(
        .ROWS(ROWS), .COLS(COLS), .PIX_W(4), .ROW_AW(4), .COL_AW(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0] m_mem [2][ROWS][COLS];
    bit       m_front, m_pend, m_tgt;
    bit [3:0] m_rd_data;
    bit       m_rd_valid, m_wr_drop;
    int       m_clr_left, m_clr_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_mem[b, r, c]) m_mem[b][r][c] = '0;
            m_front = 0; m_pend = 0; m_tgt = 0;
            m_rd_data = '0; m_rd_valid = 0; m_wr_drop = 0;
            m_clr_left = 0; m_clr_idx = 0;
        end else begin
            bit busy, swap_x, clr_acc, wr_rng, rd_rng, wr_take;
            int wr, wc, rr, rc;
            wr = int'(bus.wr_row); wc = int'(bus.wr_col);
            rr = int'(bus.rd_row); rc = int'(bus.rd_col);
            busy    = (m_clr_left > 0);
            swap_x  = m_pend && bus.frame_sync && !busy;
            clr_acc = bus.clr_req && !busy;
            rd_rng  = (rr < ROWS) && (rc < COLS);
            wr_rng  = (wr < ROWS) && (wc < COLS);
            if (bus.rd_en) m_rd_data = rd_rng ? m_mem[m_front][rr][rc] : 4'h0;
            m_rd_valid = bus.rd_en;
            wr_take = bus.we && wr_rng && !busy && !clr_acc;
            m_wr_drop = bus.we && !wr_take;
            if (wr_take) m_mem[!m_front][wr][wc] = bus.wr_data;
            if (busy) begin
                m_mem[m_tgt][m_clr_idx / COLS][m_clr_idx % COLS] = '0;
                m_clr_idx++;
                m_clr_left--;
            end else if (clr_acc) begin
                m_tgt = swap_x ? m_front : !m_front;
                m_clr_idx = 0;
                m_clr_left = NPIX;
            end
            if (swap_x) begin
                m_front = !m_front;
                m_pend = 0;
            end else if (bus.swap_req) begin
                m_pend = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("rd_data",   int'(bus.rd_data),   int'(m_rd_data));
            chk("rd_valid",  int'(bus.rd_valid),  int'(m_rd_valid));
            chk("wr_drop",   int'(bus.wr_drop),   int'(m_wr_drop));
            chk("clr_busy",  int'(bus.clr_busy),  int'(m_clr_left > 0));
            chk("swap_pend", int'(bus.swap_pend), int'(m_pend));
            chk("front_sel", int'(bus.front_sel), int'(m_front));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we = 0; bus.rd_en = 0; bus.clr_req = 0;
        bus.swap_req = 0; bus.frame_sync = 0;
    endtask

    task automatic rd(input int r, input int c);
        bus.rd_en = 1; bus.rd_row = 4'(r); bus.rd_col = 4'(c);
    endtask

    task automatic wrp(input int r, input int c, input logic [3:0] d);
        bus.we = 1; bus.wr_row = 4'(r); bus.wr_col = 4'(c); bus.wr_data = d;
    endtask

    // Read every pixel of the front buffer, each must be zero.
    task automatic sweep_zero(input string name);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rd(r, c);
                step();
                chk(name, int'(bus.rd_data), 0);
            end
        end
        idle();
    endtask

    task automatic swap_now();
        bus.swap_req = 1; step(); bus.swap_req = 0;
        bus.frame_sync = 1; step(); bus.frame_sync = 0;
    endtask

    initial begin
        logic [3:0] p_a, p_f;
        int n;
        p_a = '0; p_a[PIX_STORED] = 1'b1; p_a[PIX_R] = 1'b1;
        p_f = '0; p_f[PIX_STORED] = 1'b1; p_f[PIX_G] = 1'b1; p_f[PIX_R] = 1'b1; p_f[0] = 1'b1;
        idle();
        bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
        bus.rd_row = '0; bus.rd_col = '0;
        #1 rst_n = 0;
        repeat (3) step();
        #2 rst_n = 1;
        checking = 1;

        // Reset state and first read.
        chk("reset_rd_valid", int'(bus.rd_valid), 0);
        chk("reset_front_sel", int'(bus.front_sel), 0);
        rd(0, 0); step();
        chk("first_rd_valid", int'(bus.rd_valid), 1);
        chk("first_rd_data", int'(bus.rd_data), 0);
        chk("first_front_sel", int'(bus.front_sel), 0);
        idle();

        // Write, swap on frame_sync, read back.
        wrp(2, 5, p_a); step(); idle();
        bus.swap_req = 1; step(); bus.swap_req = 0;
        chk("swap_pend_set", int'(bus.swap_pend), 1);
        bus.frame_sync = 1; step(); bus.frame_sync = 0;
        chk("swap_pend_clr", int'(bus.swap_pend), 0);
        chk("swap_front", int'(bus.front_sel), 1);
        rd(2, 5); step();
        chk("swap_rd_data", int'(bus.rd_data), 4'b1010);
        idle();

        // Out-of-range write and read.
        wrp(8, 0, 4'hF); step(); idle();
        chk("oor_wr_drop", int'(bus.wr_drop), 1);
        rd(0, 8); step();
        chk("oor_rd_data", int'(bus.rd_data), 0);
        chk("oor_rd_valid", int'(bus.rd_valid), 1);
        idle(); step();
        chk("drop_one_cycle", int'(bus.wr_drop), 0);

        // Fill back buffer, clear it, check busy time and dropped write.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                wrp(r, c, p_f); step();
            end
        idle();
        bus.clr_req = 1; step(); bus.clr_req = 0;
        n = 0;
        while (bus.clr_busy && n < 200) begin
            if (n == 10) wrp(3, 3, 4'hF);
            step();
            if (n == 10) begin
                idle();
                chk("busy_wr_drop", int'(bus.wr_drop), 1);
            end
            n++;
        end
        chk("clr_busy_cycles", n, 64);
        swap_now();
        chk("clr_front", int'(bus.front_sel), 0);
        sweep_zero("cleared_pixel");

        // Swap requested during clear waits for clear completion.
        bus.clr_req = 1; step(); bus.clr_req = 0;
        bus.swap_req = 1; step(); bus.swap_req = 0;
        n = 0;
        while (bus.clr_busy && n < 200) begin
            if (n == 20) bus.frame_sync = 1;
            step();
            bus.frame_sync = 0;
            n++;
        end
        chk("held_front", int'(bus.front_sel), 0);
        chk("held_pend", int'(bus.swap_pend), 1);
        bus.frame_sync = 1; step(); bus.frame_sync = 0;
        chk("late_swap_front", int'(bus.front_sel), 1);
        chk("late_swap_pend", int'(bus.swap_pend), 0);

        // Reset in the middle of a clear.
        wrp(4, 4, p_f); step(); idle();
        bus.clr_req = 1; step(); bus.clr_req = 0;
        rd(1, 1);
        repeat (20) step();
        idle();
        #2 rst_n = 0;
        step();
        chk("rst_rd_data", int'(bus.rd_data), 0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_clr_busy", int'(bus.clr_busy), 0);
        chk("rst_swap_pend", int'(bus.swap_pend), 0);
        chk("rst_front_sel", int'(bus.front_sel), 0);
        chk("rst_wr_drop", int'(bus.wr_drop), 0);
        #2 rst_n = 1;
        step();
        sweep_zero("rst_front_pixel");
        swap_now();
        sweep_zero("rst_back_pixel");
        chk("rst_idle_busy", int'(bus.clr_busy), 0);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            bus.we         = ($urandom_range(2) == 0);
            bus.wr_row     = 4'($urandom_range(9));
            bus.wr_col     = 4'($urandom_range(9));
            bus.wr_data    = 4'($urandom);
            bus.rd_en      = ($urandom_range(1) == 0);
            bus.rd_row     = 4'($urandom_range(9));
            bus.rd_col     = 4'($urandom_range(9));
            bus.clr_req    = ($urandom_range(80) == 0);
            bus.swap_req   = ($urandom_range(20) == 0);
            bus.frame_sync = ($urandom_range(12) == 0);
            step();
        end
        idle();
        step();
        checking = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_buf.md
Name: led_frame_buf

Overview:
- Parametrised, double-buffered LED frame memory.
- Writers (light-pen/controller side) write pixels into the back buffer. The scan driver reads pixels from the front buffer with a registered, 1-cycle read.
- The buffers swap on request, synchronised to the scan frame boundary.
- A sequential clear engine zeroes the back buffer one pixel per cycle.

Parameters:
- ROWS, 8, number of LED rows.
- COLS, 8, number of LED columns.
- PIX_W, 4, bits per pixel ([3] stored flag, [2] G, [1] R, [0] spare at default width).
- ROW_AW, 3, row address width; must satisfy 2**ROW_AW >= ROWS.
- COL_AW, 3, column address width; must satisfy 2**COL_AW >= COLS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write strobe, back buffer.
- wr_row  in  ROW_AW  write row address.
- wr_col  in  COL_AW  write column address.
- wr_data  in  PIX_W  write pixel value.
- rd_en  in  1  read strobe, front buffer.
- rd_row  in  ROW_AW  read row address.
- rd_col  in  COL_AW  read column address.
- rd_data  out  PIX_W  registered read data.
- rd_valid  out  1  high the cycle after an accepted read.
- clr_req  in  1  pulse: start clearing the back buffer.
- clr_busy  out  1  clear engine active.
- swap_req  in  1  pulse: request a front/back swap.
- frame_sync  in  1  one-cycle pulse from scan driver at frame start.
- swap_pend  out  1  swap requested, not yet done.
- front_sel  out  1  index of the buffer currently displayed (0/1).
- wr_drop  out  1  one-cycle pulse: a write was ignored.

Behaviour:
- Reset (async, rst_n low):
  - Both buffers, all pixels = 0.
  - rd_data=0, rd_valid=0, clr_busy=0, swap_pend=0, front_sel=0, wr_drop=0.
  - Clear FSM returns to IDLE.
  - Reset asserted mid-clear or mid-swap aborts it; the state after reset is exactly the reset state.
- Storage: two arrays of ROWS x COLS x PIX_W. Back buffer index = ~front_sel.
- Write:
  - When we=1, wr_row<ROWS, wr_col<COLS and clr_busy=0, wr_data is stored into back[wr_row][wr_col] at the clock edge.
  - When we=1 with an out-of-range address, or while clr_busy=1 (including the clr_req acceptance cycle), nothing is stored and wr_drop pulses the next cycle.
- Read:
  - When rd_en=1 with an in-range address, rd_data <= front[rd_row][rd_col] and rd_valid <= 1 next cycle. Latency is 1.
  - When rd_en=1 with an out-of-range address, rd_data <= 0 and rd_valid <= 1.
  - When rd_en=0, rd_valid <= 0 and rd_data holds its last value.
  - A read in the same cycle as a swap uses the pre-swap front_sel.
  - Reads and writes never alias (different buffers); no collision logic is needed.
- Clear FSM:
  - States: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req. Row/column counters reset to 0; the target buffer is latched as the current back buffer.
  - CLEAR writes 0 to one pixel per cycle, column-major inner (col increments; at COLS-1 it wraps to 0 and row increments).
  - After pixel (ROWS-1, COLS-1) the FSM returns to IDLE. Total busy time = ROWS*COLS cycles.
  - clr_busy = (state==CLEAR).
  - clr_req while busy is ignored.
- Swap:
  - swap_req sets swap_pend. A repeated swap_req while pending is a no-op.
  - The swap executes at the edge where swap_pend=1, frame_sync=1 and clr_busy=0: front_sel toggles and swap_pend clears.
  - swap_req and frame_sync in the same cycle: the request is only registered; the swap waits for the next frame_sync.
  - A pending swap is held through a clear and taken at the first frame_sync after clear completes.
  - clr_req in the same cycle as a swap execution: the clear targets the post-swap back buffer.
- Widths: row/column counters are ROW_AW/COL_AW bits. Compare against ROWS-1 / COLS-1, not power-of-two wrap.

Decomposition:
- Shared package led_pkg holds:
  - Default ROWS/COLS/PIX_W.
  - Pixel bit-index constants: PIX_STORED=3, PIX_G=2, PIX_R=1.
  - Clear-state enum (CLR_IDLE, CLR_RUN).
- One natural sub-module: led_clr_seq (clear FSM plus row/column counters; outputs busy, addr, wr strobe), instantiated once.
- The storage arrays and the swap logic stay in the top module.

Test Plan:
- Reset, then rd_en at (0,0): rd_valid=1 next cycle, rd_data=0, front_sel=0.
- Write 4'b1010 at (2,5), swap_req, frame_sync pulse, read (2,5) -> rd_data=4'b1010 one cycle later; front_sel=1; swap_pend 1 then 0.
- Write to (8,0) with ROWS=8: wr_drop pulses, no pixel changes. Read (0,8) -> rd_data=0, rd_valid=1.
- Fill the back buffer with 4'hF, clr_req: clr_busy high exactly 64 cycles. A write during busy -> wr_drop, ignored. After swap, every pixel reads 0.
- swap_req during a clear, with frame_sync pulsed mid-clear: no swap. The first frame_sync after clr_busy falls toggles front_sel.
- Assert rst_n low mid-clear (cycle 20): all outputs return to reset values, both buffers read 0, and the FSM resumes IDLE after release.
